hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the decode/execute path. It tracks in-flight register writes in a shadow of the EX/MEM/WB stages and drives the operand bypass selects for decode op1/op2.
- It stalls IF/DE on load-use and multi-cycle EX hazards, and flushes IF/DE and DE/EX on a taken jump.
- It counts stall cycles for performance monitoring.

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_fwd_sel.sv | 29 ++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the decode/execute hazard controller:
// opcode classes, operand bypass encodings and the per-cycle pipeline action.
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [6:0] INST_TYPE_I    = 7'b0010011;
    localparam logic [6:0] INST_TYPE_R    = 7'b0110011;
    localparam logic [6:0] INST_TYPE_LOAD = 7'b0000011;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ACT_NORMAL = 2'd0,
        ACT_LDHAZ  = 2'd1,
        ACT_JUMP   = 2'd2,
        ACT_BUSY   = 2'd3
    } hz_act_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Combinational bypass-source matcher for one decode operand.
// The youngest valid in-flight writer wins (EX, then MEM, then WB); x0 never forwards.
module hazard_fwd_sel #(
    parameter int REG_AW = 5
) (
    input  logic              rd_en_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [2:0]        vld_i,
    input  logic [REG_AW-1:0] ex_addr_i,
    input  logic [REG_AW-1:0] mem_addr_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    output logic [1:0]        sel_o
);
    import hazard_ctrl_pkg::*;

    always_comb begin
        sel_o = FWD_REG;
        if (rd_en_i && (rd_addr_i != '0)) begin
            if (vld_i[0] && (ex_addr_i == rd_addr_i)) begin
                sel_o = FWD_EX;
            end else if (vld_i[1] && (mem_addr_i == rd_addr_i)) begin
                sel_o = FWD_MEM;
            end else if (vld_i[2] && (wb_addr_i == rd_addr_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode/execute sequencing controller: shadows in-flight register writes,
// drives operand bypass selects, stalls/flushes IF/DE and counts stall cycles.
module hazard_ctrl #(
    parameter int CNT_W  = 32,
    parameter int REG_AW = hazard_ctrl_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              de_valid,
    input  logic              rd_reg1_flag,
    input  logic              rd_reg2_flag,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    input  logic              wr_reg_en,
    input  logic [REG_AW-1:0] wr_reg_addr,
    input  logic              de_is_load,
    input  logic              ex_busy,
    input  logic              jump_flag,
    output logic              stall_pc,
    output logic              stall_ifde,
    output logic              flush_ifde,
    output logic              bubble_deex,
    output logic [1:0]        fwd1_sel,
    output logic [1:0]        fwd2_sel,
    output logic [CNT_W-1:0]  stall_cnt
);
    import hazard_ctrl_pkg::*;

    // Shadow entries, bit/slot 0 = EX, 1 = MEM, 2 = WB
    logic [2:0]        vld_q, vld_d;
    logic [2:0]        ld_q, ld_d;
    logic [REG_AW-1:0] ex_addr_q, ex_addr_d;
    logic [REG_AW-1:0] mem_addr_q, mem_addr_d;
    logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic    rd1_act, rd2_act, ld_haz, de_enter;
    logic    stall_c, flush_c, bubble_c;
    hz_act_e act;

    assign rd1_act  = de_valid && rd_reg1_flag && (rd_addr1 != '0);
    assign rd2_act  = de_valid && rd_reg2_flag && (rd_addr2 != '0);
    assign de_enter = de_valid && wr_reg_en && (wr_reg_addr != '0);
    assign ld_haz   = vld_q[0] && ld_q[0] &&
                      ((rd1_act && (rd_addr1 == ex_addr_q)) ||
                       (rd2_act && (rd_addr2 == ex_addr_q)));

    always_comb begin
        if (ex_busy) begin
            act = ACT_BUSY;
        end else if (jump_flag) begin
            act = ACT_JUMP;
        end else if (ld_haz) begin
            act = ACT_LDHAZ;
        end else begin
            act = ACT_NORMAL;
        end
    end

    // Busy holds everything; the other actions advance the shadow one stage.
    always_comb begin
        stall_c    = 1'b0;
        flush_c    = 1'b0;
        bubble_c   = 1'b0;
        vld_d      = vld_q;
        ld_d       = ld_q;
        ex_addr_d  = ex_addr_q;
        mem_addr_d = mem_addr_q;
        wb_addr_d  = wb_addr_q;
        if (act != ACT_BUSY) begin
            vld_d      = {vld_q[1], vld_q[0], 1'b0};
            ld_d       = {ld_q[1], ld_q[0], 1'b0};
            mem_addr_d = ex_addr_q;
            wb_addr_d  = mem_addr_q;
        end
        case (act)
            ACT_BUSY: begin
                stall_c = 1'b1;
            end
            ACT_JUMP: begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
            end
            ACT_LDHAZ: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
            end
            default: begin
                vld_d[0]  = de_enter;
                ld_d[0]   = de_is_load;
                ex_addr_d = wr_reg_addr;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry payload is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        ld_q       <= ld_d;
        ex_addr_q  <= ex_addr_d;
        mem_addr_q <= mem_addr_d;
        wb_addr_q  <= wb_addr_d;
    end

    assign stall_pc    = stall_c && rst_n;
    assign stall_ifde  = stall_c && rst_n;
    assign flush_ifde  = flush_c && rst_n;
    assign bubble_deex = bubble_c && rst_n;
    assign stall_cnt   = cnt_q;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd1 (
        .rd_en_i    (de_valid && rd_reg1_flag),
        .rd_addr_i  (rd_addr1),
        .vld_i      (vld_q),
        .ex_addr_i  (ex_addr_q),
        .mem_addr_i (mem_addr_q),
        .wb_addr_i  (wb_addr_q),
        .sel_o      (fwd1_sel)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd2 (
        .rd_en_i    (de_valid && rd_reg2_flag),
        .rd_addr_i  (rd_addr2),
        .vld_i      (vld_q),
        .ex_addr_i  (ex_addr_q),
        .mem_addr_i (mem_addr_q),
        .wb_addr_i  (wb_addr_q),
        .sel_o      (fwd2_sel)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: a default instance plus a CNT_W=4
// instance on the same inputs to exercise counter saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       de_valid, rd_reg1_flag, rd_reg2_flag, wr_reg_en, de_is_load;
    logic       ex_busy, jump_flag;
    logic [4:0] rd_addr1, rd_addr2, wr_reg_addr;

    logic        stall_pc, stall_ifde, flush_ifde, bubble_deex;
    logic [1:0]  fwd1_sel, fwd2_sel;
    logic [31:0] stall_cnt;
    logic        stall_pc4, stall_ifde4, flush_ifde4, bubble_deex4;
    logic [1:0]  fwd1_sel4, fwd2_sel4;
    logic [3:0]  stall_cnt4;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    typedef struct {
        string      tag;
        logic [7:0] ctl;
        int         cnt;
    } exp_t;
    exp_t sb[$];

    hazard_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .de_valid(de_valid),
        .rd_reg1_flag(rd_reg1_flag), .rd_reg2_flag(rd_reg2_flag),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .wr_reg_en(wr_reg_en), .wr_reg_addr(wr_reg_addr), .de_is_load(de_is_load),
        .ex_busy(ex_busy), .jump_flag(jump_flag),
        .stall_pc(stall_pc), .stall_ifde(stall_ifde), .flush_ifde(flush_ifde),
        .bubble_deex(bubble_deex), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .de_valid(de_valid),
        .rd_reg1_flag(rd_reg1_flag), .rd_reg2_flag(rd_reg2_flag),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .wr_reg_en(wr_reg_en), .wr_reg_addr(wr_reg_addr), .de_is_load(de_is_load),
        .ex_busy(ex_busy), .jump_flag(jump_flag),
        .stall_pc(stall_pc4), .stall_ifde(stall_ifde4), .flush_ifde(flush_ifde4),
        .bubble_deex(bubble_deex4), .fwd1_sel(fwd1_sel4), .fwd2_sel(fwd2_sel4),
        .stall_cnt(stall_cnt4)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_all(input string tag, input logic [7:0] ctl, input int cnt);
        logic [7:0] got, got4;
        logic [3:0] cnt4;
        got  = {stall_pc, stall_ifde, flush_ifde, bubble_deex, fwd1_sel, fwd2_sel};
        got4 = {stall_pc4, stall_ifde4, flush_ifde4, bubble_deex4, fwd1_sel4, fwd2_sel4};
        cnt4 = (cnt > 15) ? 4'hF : 4'(cnt);
        checks++;
        assert (got === ctl) else begin
            failures++;
            $error("FAIL %s ctl got=%b exp=%b", tag, got, ctl);
        end
        checks++;
        assert (got4 === ctl) else begin
            failures++;
            $error("FAIL %s ctl4 got=%b exp=%b", tag, got4, ctl);
        end
        checks++;
        assert (stall_cnt === 32'(cnt)) else begin
            failures++;
            $error("FAIL %s stall_cnt got=%0d exp=%0d", tag, stall_cnt, cnt);
        end
        checks++;
        assert (stall_cnt4 === cnt4) else begin
            failures++;
            $error("FAIL %s stall_cnt4 got=%0d exp=%0d", tag, stall_cnt4, cnt4);
        end
    endtask

    // ctl4 = {stall_pc, stall_ifde, flush_ifde, bubble_deex}
    task automatic step(input string tag, input logic dv,
                        input logic r1f, input logic [4:0] a1,
                        input logic r2f, input logic [4:0] a2,
                        input logic wen, input logic [4:0] wa, input logic ld,
                        input logic busy, input logic jmp,
                        input logic [3:0] ctl4, input logic [1:0] f1, input logic [1:0] f2);
        exp_t e;
        de_valid = dv; rd_reg1_flag = r1f; rd_addr1 = a1; rd_reg2_flag = r2f; rd_addr2 = a2;
        wr_reg_en = wen; wr_reg_addr = wa; de_is_load = ld; ex_busy = busy; jump_flag = jmp;
        sb.push_back('{tag, {ctl4, f1, f2}, exp_cnt});
        #1;
        e = sb.pop_front();
        check_all(e.tag, e.ctl, e.cnt);
        if (ctl4[3]) exp_cnt++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        de_valid = 0; rd_reg1_flag = 0; rd_reg2_flag = 0; wr_reg_en = 0; de_is_load = 0;
        ex_busy = 0; jump_flag = 0; rd_addr1 = 0; rd_addr2 = 0; wr_reg_addr = 0;
        #2;
        check_all("reset", 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b1;

        //   tag               dv r1f a1 r2f a2 wen wa ld busy jmp  ctl4     f1 f2
        step("ori_x1",          1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 0);
        step("or_x2_x1_x1",     1, 1, 1, 1, 1, 1, 2, 0, 0, 0, 4'b0000, 1, 1);
        step("nop",             0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        step("rd_x1_wb",        1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 0);
        step("wr_x3_a",         1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 4'b0000, 0, 0);
        step("wr_x3_b",         1, 1, 3, 0, 0, 1, 3, 0, 0, 0, 4'b0000, 1, 0);
        step("rd_x3_ex_mem",    1, 1, 3, 1, 3, 0, 0, 0, 0, 0, 4'b0000, 1, 1);
        step("rd_x3_dist2",     1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2, 0);
        step("rd_x3_dist3",     1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 0);
        step("lw_x4",           1, 1, 0, 0, 0, 1, 4, 1, 0, 0, 4'b0000, 0, 0);
        step("or_x5_x4_haz",    1, 1, 4, 1, 0, 1, 5, 0, 0, 0, 4'b1101, 1, 0);
        step("or_x5_x4_go",     1, 1, 4, 1, 0, 1, 5, 0, 0, 0, 4'b0000, 2, 0);
        step("lw_x6",           1, 1, 0, 0, 0, 1, 6, 1, 0, 0, 4'b0000, 0, 0);
        step("jmp_over_ldhaz",  1, 1, 6, 0, 0, 1, 7, 0, 0, 1, 4'b0011, 1, 0);
        step("post_jmp",        1, 1, 6, 1, 5, 0, 0, 0, 0, 0, 4'b0000, 2, 3);
        step("wr_x8",           1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 4'b0000, 0, 0);
        step("busy1",           1, 1, 8, 0, 0, 0, 0, 0, 1, 0, 4'b1100, 1, 0);
        step("busy2_jmp",       1, 1, 8, 0, 0, 0, 0, 0, 1, 1, 4'b1100, 1, 0);
        step("busy3",           1, 1, 8, 0, 0, 0, 0, 0, 1, 0, 4'b1100, 1, 0);
        step("busy4",           1, 1, 8, 0, 0, 0, 0, 0, 1, 0, 4'b1100, 1, 0);
        step("busy_drop_jmp",   1, 1, 8, 0, 0, 0, 0, 0, 0, 1, 4'b0011, 1, 0);
        step("post_busy",       1, 1, 8, 1, 6, 0, 0, 0, 0, 0, 4'b0000, 2, 0);
        step("wr_x0",           1, 1, 8, 0, 0, 1, 0, 1, 0, 0, 4'b0000, 3, 0);
        step("rd_x0",           1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        step("wr_x9",           1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 4'b0000, 0, 0);
        step("flag0_rd_x9",     1, 0, 9, 1, 9, 0, 0, 0, 0, 0, 4'b0000, 0, 1);
        for (int i = 0; i < 14; i++) begin
            step($sformatf("sat%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1100, 0, 0);
        end
        step("busy_pre_rst",    1, 1, 9, 0, 0, 0, 0, 0, 1, 0, 4'b1100, 2, 0);

        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check_all("rst_mid_stall", 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_rd_x9",  1, 1, 9, 1, 9, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        step("post_rst_lw",     1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 4'b0000, 0, 0);
        step("post_rst_ldhaz",  1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 4'b1101, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
